penc_arb: RTL

Parametrised, registered priority encoder and arbiter; the N-input generalisation of the team's 4-to-2 priority encoder. It samples an N-bit request vector, selects one active request, and presents that request's binary index and one-hot grant on a valid/ready output handshake. It supports fixed priority, where the highest index wins, and round-robin priority. It sits between request sources, such as interrupt lines or FIFO-not-empty flags, and a single consumer that services one request at a time.

---
 rtl/penc_pkg.sv | 14 +
 rtl/penc_core.sv | 25 ++
 rtl/penc_arb.sv | 116 +++++++++++
 3 files changed

// File: rtl/penc_pkg.sv
// Shared types and helpers for the penc_arb priority encoder / arbiter.
package penc_pkg;

  localparam int unsigned MODE_FIXED = 0;
  localparam int unsigned MODE_RR    = 1;

  typedef enum logic {StIdle, StHold} state_e;

  // Index width that stays at least one bit wide for degenerate N.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/penc_core.sv
// Combinational highest-set-bit encoder: the N-input 4-to-2 priority encoder.
module penc_core
  import penc_pkg::*;
#(
  parameter int unsigned N = 8,
  localparam int unsigned W = idx_width(N)
) (
  input  logic [N-1:0] req,
  output logic         found,
  output logic [W-1:0] index
);

  // Ascending scan: the last set bit seen is the highest one.
  always_comb begin
    found = 1'b0;
    index = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (req[i]) begin
        found = 1'b1;
        index = W'(i);
      end
    end
  end

endmodule

// File: rtl/penc_arb.sv
// Registered priority encoder / arbiter with valid/ready output and optional
// round-robin rotation of priority.
module penc_arb
  import penc_pkg::*;
#(
  parameter int unsigned N = 8,
  parameter int unsigned ROUND_ROBIN = MODE_FIXED,
  localparam int unsigned W = idx_width(N)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic         out_ready,
  output logic         out_valid,
  output logic [W-1:0] idx,
  output logic [N-1:0] grant,
  output logic         any
);

  state_e         state_q, state_d;
  logic [W-1:0]   idx_q, idx_d;
  logic [N-1:0]   grant_q, grant_d;
  logic           any_q;
  logic           load;
  logic           req_found;
  logic [W-1:0]   full_idx;
  logic [W-1:0]   win_idx;

  assign out_valid = (state_q == StHold);
  assign load      = !out_valid || out_ready;

  penc_core #(.N(N)) u_core_full (
    .req   (req),
    .found (req_found),
    .index (full_idx)
  );

  if (ROUND_ROBIN == MODE_RR) begin : g_rr
    logic [W-1:0] ptr_q, ptr_d;
    logic [N-1:0] mask;
    logic         masked_found;
    logic [W-1:0] masked_idx;

    // The pointer update feeds this cycle's selection so back-to-back
    // grants rotate without a bubble.
    always_comb begin
      ptr_d = ptr_q;
      if (out_valid && out_ready) begin
        ptr_d = (idx_q == '0) ? W'(N - 1) : idx_q - W'(1);
      end
    end

    always_comb begin
      mask = '0;
      for (int unsigned i = 0; i < N; i++) begin
        mask[i] = (W'(i) <= ptr_d);
      end
    end

    penc_core #(.N(N)) u_core_masked (
      .req   (req & mask),
      .found (masked_found),
      .index (masked_idx)
    );

    // Nothing at or below ptr means the winner is the highest bit above it.
    assign win_idx = masked_found ? masked_idx : full_idx;

    always_ff @(posedge clk) begin
      if (rst) begin
        ptr_q <= W'(N - 1);
      end else begin
        ptr_q <= ptr_d;
      end
    end
  end else begin : g_fixed
    assign win_idx = full_idx;
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    grant_d = grant_q;
    if (load) begin
      if (req_found) begin
        state_d          = StHold;
        idx_d            = win_idx;
        grant_d          = '0;
        grant_d[win_idx] = 1'b1;
      end else begin
        state_d = StIdle;
        idx_d   = '0;
        grant_d = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      idx_q   <= '0;
      grant_q <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      grant_q <= grant_d;
      any_q   <= |req;
    end
  end

  assign idx   = idx_q;
  assign grant = grant_q;
  assign any   = any_q;

endmodule
